// File: rtl/tex_types.sv
// Shared texture configuration types: field widths, DCR offset map and the
// per-stage configuration record held by the register bank.
package tex_types;

  localparam int TEX_LOD_MAX     = 11;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_MIPOFF_BITS = 25;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 1;

  localparam int TEX_DCR_STAGE   = 0;
  localparam int TEX_DCR_BADDR   = 1;
  localparam int TEX_DCR_LOGDIM  = 2;
  localparam int TEX_DCR_FORMAT  = 3;
  localparam int TEX_DCR_FILTER  = 4;
  localparam int TEX_DCR_WRAP    = 5;
  localparam int TEX_DCR_COMMIT  = 6;
  localparam int TEX_DCR_MIPOFF0 = 7;
  localparam int TEX_DCR_COUNT   = TEX_DCR_MIPOFF0 + TEX_LOD_MAX + 1;

  // Index 0 of logdims/wraps is the u axis, index 1 the v axis.
  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                     baddr;
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]    mipoff;
    logic [1:0][TEX_LOD_BITS-1:0]                 logdims;
    logic [1:0][TEX_WRAP_BITS-1:0]                wraps;
    logic [TEX_FORMAT_BITS-1:0]                   format;
    logic [TEX_FILTER_BITS-1:0]                   filter;
  } tex_dcrs_t;

  function automatic int stage_bits(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/tex_stage_drain.sv
// Per-stage in-flight tracking: counts outstanding texture requests and holds
// a commit request until the stage has fully drained, then strobes apply.
module tex_stage_drain #(
  parameter int INFLIGHT_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic done,
  input  logic commit,
  output logic cnt_full,
  output logic pending,
  output logic apply
);

  logic [INFLIGHT_BITS-1:0] cnt;
  logic                     dec;

  // A retire on an idle stage is spurious and must not wrap the counter.
  assign dec      = done && (cnt != '0);
  assign cnt_full = &cnt;
  assign apply    = pending && (cnt == '0);

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values of cnt/pending regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (start && !dec) begin
        cnt <= cnt + 1'b1;
      end else if (dec && !start) begin
        cnt <= cnt - 1'b1;
      end

      if (apply) begin
        pending <= 1'b0;
      end else if (commit) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && done) begin
      assert (cnt != '0)
        else $error("tex_stage_drain: retire seen with no request in flight");
    end
  end

endmodule

// File: rtl/tex_dcr_bank.sv
// Texture DCR bank: decodes DCR writes into per-stage shadow configs and
// promotes each shadow to the active copy once its stage has no work in flight.
module tex_dcr_bank
  import tex_types::*;
#(
  parameter int                         NUM_STAGES    = 2,
  parameter int                         NUM_READERS   = 1,
  parameter int                         DCR_ADDR_BITS = 12,
  parameter int                         DCR_DATA_BITS = 32,
  parameter logic [DCR_ADDR_BITS-1:0]   DCR_BASE      = 'h010,
  parameter int                         INFLIGHT_BITS = 4,
  localparam int                        STAGE_BITS    = stage_bits(NUM_STAGES)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    dcr_wr_valid,
  input  logic [DCR_ADDR_BITS-1:0]                dcr_wr_addr,
  input  logic [DCR_DATA_BITS-1:0]                dcr_wr_data,
  output logic                                    dcr_wr_ready,
  input  logic                                    req_start_valid,
  input  logic [STAGE_BITS-1:0]                   req_start_stage,
  output logic                                    req_start_ready,
  input  logic                                    req_done_valid,
  input  logic [STAGE_BITS-1:0]                   req_done_stage,
  input  logic [NUM_READERS-1:0][STAGE_BITS-1:0]  rd_stage,
  output tex_dcrs_t [NUM_READERS-1:0]             rd_dcrs,
  output logic [NUM_STAGES-1:0]                   commit_pending
);

  logic [STAGE_BITS-1:0]         sel;
  tex_dcrs_t [NUM_STAGES-1:0]    shadow;
  tex_dcrs_t [NUM_STAGES-1:0]    active;
  logic [DCR_ADDR_BITS-1:0]      offset;
  logic                          wr_fire;
  logic [NUM_STAGES-1:0]         start_fire;
  logic [NUM_STAGES-1:0]         done_hit;
  logic [NUM_STAGES-1:0]         commit_set;
  logic [NUM_STAGES-1:0]         cnt_full;
  logic [NUM_STAGES-1:0]         apply;

  assign offset  = dcr_wr_addr - DCR_BASE;
  assign wr_fire = dcr_wr_valid && dcr_wr_ready;

  // Writes stall while the selected stage waits to drain; issue stalls while
  // the requested stage drains or its counter is saturated.
  always_comb begin
    dcr_wr_ready    = 1'b1;
    req_start_ready = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (sel == STAGE_BITS'(s)) begin
        dcr_wr_ready = ~commit_pending[s];
      end
      if (req_start_stage == STAGE_BITS'(s)) begin
        req_start_ready = ~commit_pending[s] & ~cnt_full[s];
      end
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    assign start_fire[s] = req_start_valid && req_start_ready &&
                           (req_start_stage == STAGE_BITS'(s));
    assign done_hit[s]   = req_done_valid && (req_done_stage == STAGE_BITS'(s));
    assign commit_set[s] = wr_fire && (sel == STAGE_BITS'(s)) &&
                           (offset == DCR_ADDR_BITS'(TEX_DCR_COMMIT));

    tex_stage_drain #(
      .INFLIGHT_BITS (INFLIGHT_BITS)
    ) u_drain (
      .clk      (clk),
      .reset    (reset),
      .start    (start_fire[s]),
      .done     (done_hit[s]),
      .commit   (commit_set[s]),
      .cnt_full (cnt_full[s]),
      .pending  (commit_pending[s]),
      .apply    (apply[s])
    );
  end

  // Out-of-range stage numbers are dropped so sel always names a real stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel <= '0;
    end else if (wr_fire && (offset == DCR_ADDR_BITS'(TEX_DCR_STAGE)) &&
                 (dcr_wr_data < DCR_DATA_BITS'(NUM_STAGES))) begin
      sel <= dcr_wr_data[STAGE_BITS-1:0];
    end
  end

  // NOTE: the config copies are small flop banks, not RAM, so they take the
  // synchronous reset like any other state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (wr_fire) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (sel == STAGE_BITS'(s)) begin
          case (offset)
            DCR_ADDR_BITS'(TEX_DCR_BADDR):
              shadow[s].baddr <= dcr_wr_data[TEX_ADDR_BITS-1:0];
            DCR_ADDR_BITS'(TEX_DCR_LOGDIM): begin
              shadow[s].logdims[0] <= dcr_wr_data[TEX_LOD_BITS-1:0];
              shadow[s].logdims[1] <= dcr_wr_data[2*TEX_LOD_BITS-1:TEX_LOD_BITS];
            end
            DCR_ADDR_BITS'(TEX_DCR_FORMAT):
              shadow[s].format <= dcr_wr_data[TEX_FORMAT_BITS-1:0];
            DCR_ADDR_BITS'(TEX_DCR_FILTER):
              shadow[s].filter <= dcr_wr_data[TEX_FILTER_BITS-1:0];
            DCR_ADDR_BITS'(TEX_DCR_WRAP): begin
              shadow[s].wraps[0] <= dcr_wr_data[TEX_WRAP_BITS-1:0];
              shadow[s].wraps[1] <= dcr_wr_data[2*TEX_WRAP_BITS-1:TEX_WRAP_BITS];
            end
            default: begin
              for (int l = 0; l <= TEX_LOD_MAX; l++) begin
                if (offset == DCR_ADDR_BITS'(TEX_DCR_MIPOFF0 + l)) begin
                  shadow[s].mipoff[l] <= dcr_wr_data[TEX_MIPOFF_BITS-1:0];
                end
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= '0;
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (apply[s]) begin
          active[s] <= shadow[s];
        end
      end
    end
  end

  // NOTE: rd_dcrs is defaulted before the search loop so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_dcrs = '0;
    for (int r = 0; r < NUM_READERS; r++) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (rd_stage[r] == STAGE_BITS'(s)) begin
          rd_dcrs[r] = active[s];
        end
      end
    end
  end

endmodule
